// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer: state encoding,
// reset/restart PC, halt opcode and the branch-offset helper.
package pc_sequencer_pkg;

  localparam int unsigned INSTR_BYTES     = 4;
  localparam logic [31:0] PC_START_DEF    = 32'h0040_0020;
  localparam logic [31:0] HALT_OPCODE_DEF = 32'h0000_000C;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_FAULT = 2'b10
  } state_e;

  // Signed word offset turned into a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect/control inputs from decode and PC/status outputs toward the
// instruction SRAM, bundled as one interface.
interface pc_sequencer_if;
  logic        stall;
  logic        restart;
  logic [31:0] ins_in;
  logic        br_taken;
  logic [15:0] br_imm;
  logic        jump;
  logic [25:0] j_index;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        fault;
  logic [31:0] ins_count;

  modport master (
    output stall, restart, ins_in, br_taken, br_imm, jump, j_index, jr, jr_addr,
    input  pc_out, pc_plus4, halted, fault, ins_count
  );

  modport slave (
    input  stall, restart, ins_in, br_taken, br_imm, jump, j_index, jr, jr_addr,
    output pc_out, pc_plus4, halted, fault, ins_count
  );
endinterface

// File: rtl/adder_32.sv
// Plain 32-bit modulo adder shared by the PC increment and branch-target paths.
module adder_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);
  assign sum_o = a_i + b_i;
endmodule

// File: rtl/pc_sequencer_pc_next_mux.sv
// Combinational next-PC selection: target computation, JR > jump > branch > +4
// priority, and word-alignment check on the selected target.
module pc_next_mux
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic        br_taken_i,
  input  logic [15:0] br_imm_i,
  input  logic        jump_i,
  input  logic [25:0] j_index_i,
  input  logic        jr_i,
  input  logic [31:0] jr_addr_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  logic [31:0] br_off;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign br_off   = branch_offset(br_imm_i);
  assign j_target = {pc_plus4_i[31:28], j_index_i, 2'b00};

  adder_32 u_br_add (
    .a_i   (pc_plus4_i),
    .b_i   (br_off),
    .sum_o (br_target)
  );

  always_comb begin
    next_pc_o = pc_plus4_i;
    if (jr_i)            next_pc_o = jr_addr_i;
    else if (jump_i)     next_pc_o = j_target;
    else if (br_taken_i) next_pc_o = br_target;
  end

  // Only JR can actually produce a non-word address; the check is generic.
  assign misaligned_o = |next_pc_o[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, retired-instruction counter and RUN/HALT/FAULT control for
// the single-cycle processor fetch stage.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] PC_START    = PC_START_DEF,
  parameter logic [31:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  pc_sequencer_if.slave  bus
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic        halted_q, fault_q;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        misaligned;

  adder_32 u_inc (
    .a_i   (pc_q),
    .b_i   (32'(INSTR_BYTES)),
    .sum_o (pc_plus4)
  );

  pc_next_mux u_next (
    .pc_plus4_i   (pc_plus4),
    .br_taken_i   (bus.br_taken),
    .br_imm_i     (bus.br_imm),
    .jump_i       (bus.jump),
    .j_index_i    (bus.j_index),
    .jr_i         (bus.jr),
    .jr_addr_i    (bus.jr_addr),
    .next_pc_o    (next_pc),
    .misaligned_o (misaligned)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    case (state_q)
      ST_RUN: begin
        if (bus.stall) begin
          state_d = ST_RUN;
        end else if (bus.ins_in == HALT_OPCODE) begin
          // The halting instruction itself retires.
          count_d = count_q + 32'd1;
          state_d = ST_HALT;
        end else if (misaligned) begin
          state_d = ST_FAULT;
        end else begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
        end
      end
      ST_HALT, ST_FAULT: begin
        if (bus.restart) begin
          pc_d    = PC_START;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      pc_q     <= PC_START;
      count_q  <= 32'd0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      halted_q <= (state_d == ST_HALT);
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.halted    = halted_q;
  assign bus.fault     = fault_q;
  assign bus.ins_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each stimulus cycle queues the hand-computed
// state expected after the next edge; a monitor pops and compares.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        h;
    logic        f;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic idle();
    reset_n      = 1'b1;
    bus.stall    = 1'b0;
    bus.restart  = 1'b0;
    bus.ins_in   = 32'h0000_0000;
    bus.br_taken = 1'b0;
    bus.br_imm   = 16'h0000;
    bus.jump     = 1'b0;
    bus.j_index  = 26'h0;
    bus.jr       = 1'b0;
    bus.jr_addr  = 32'h0;
  endtask

  // Inputs are already set; queue the post-edge expectation and advance.
  task automatic cyc(input string nm, input logic [31:0] epc, input logic [31:0] ecnt,
                     input logic eh, input logic ef);
    exp_t e;
    e.nm = nm; e.pc = epc; e.cnt = ecnt; e.h = eh; e.f = ef;
    sb.push_back(e);
    @(negedge clk);
    idle();
  endtask

  task automatic chk(input string nm, input string what, input logic [31:0] act,
                     input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %08h, expected %08h", nm, what, act, req);
    end
  endtask

  // Monitor: sample 2 time units after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.nm, "pc_out",    bus.pc_out,    e.pc);
        chk(e.nm, "pc_plus4",  bus.pc_plus4,  e.pc + 32'd4);
        chk(e.nm, "ins_count", bus.ins_count, e.cnt);
        chk(e.nm, "halted",    {31'd0, bus.halted}, {31'd0, e.h});
        chk(e.nm, "fault",     {31'd0, bus.fault},  {31'd0, e.f});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b0; cyc("reset0", 32'h0040_0020, 0, 0, 0);
    reset_n = 1'b0; cyc("reset1", 32'h0040_0020, 0, 0, 0);

    cyc("seq1", 32'h0040_0024, 1, 0, 0);
    cyc("seq2", 32'h0040_0028, 2, 0, 0);
    cyc("seq3", 32'h0040_002C, 3, 0, 0);
    cyc("seq4", 32'h0040_0030, 4, 0, 0);

    bus.br_taken = 1'b1; bus.br_imm = 16'hFFFC;
    cyc("br_back", 32'h0040_0024, 5, 0, 0);
    cyc("seq5", 32'h0040_0028, 6, 0, 0);
    cyc("seq6", 32'h0040_002C, 7, 0, 0);
    cyc("seq7", 32'h0040_0030, 8, 0, 0);
    bus.br_taken = 1'b1; bus.br_imm = 16'h0002;
    cyc("br_fwd", 32'h0040_003C, 9, 0, 0);

    bus.jr = 1'b1; bus.jr_addr = 32'h0040_0100;
    bus.jump = 1'b1; bus.j_index = 26'h0100010; bus.br_taken = 1'b1; bus.br_imm = 16'h0040;
    cyc("jr_wins", 32'h0040_0100, 10, 0, 0);
    bus.jump = 1'b1; bus.j_index = 26'h0100010; bus.br_taken = 1'b1; bus.br_imm = 16'h0040;
    cyc("jump_wins", 32'h0040_0040, 11, 0, 0);

    bus.stall = 1'b1; bus.jump = 1'b1; bus.j_index = 26'h0000100;
    cyc("stall1", 32'h0040_0040, 11, 0, 0);
    bus.stall = 1'b1; bus.jump = 1'b1; bus.j_index = 26'h0000100;
    cyc("stall2", 32'h0040_0040, 11, 0, 0);

    bus.jr = 1'b1; bus.jr_addr = 32'h0040_0102;
    cyc("jr_misalign", 32'h0040_0040, 11, 0, 1);
    bus.jr = 1'b1; bus.jr_addr = 32'h0040_0200;
    cyc("fault_frozen", 32'h0040_0040, 11, 0, 1);
    bus.restart = 1'b1; bus.stall = 1'b1;
    cyc("fault_restart", 32'h0040_0020, 11, 0, 0);

    bus.restart = 1'b1;
    cyc("restart_in_run", 32'h0040_0024, 12, 0, 0);

    bus.ins_in = 32'h0000_000C;
    cyc("halt", 32'h0040_0024, 13, 1, 0);
    cyc("halt_frozen", 32'h0040_0024, 13, 1, 0);
    bus.jump = 1'b1; bus.j_index = 26'h0000100; bus.stall = 1'b1;
    cyc("halt_ignores", 32'h0040_0024, 13, 1, 0);
    bus.restart = 1'b1;
    cyc("halt_restart", 32'h0040_0020, 13, 0, 0);

    bus.ins_in = 32'h0000_000C;
    cyc("halt2", 32'h0040_0020, 14, 1, 0);
    reset_n = 1'b0;
    cyc("reset_halted", 32'h0040_0020, 0, 0, 0);
    cyc("seq_after_rst", 32'h0040_0024, 1, 0, 0);
    reset_n = 1'b0; bus.stall = 1'b1;
    cyc("reset_stall", 32'h0040_0020, 0, 0, 0);

    bus.jr = 1'b1; bus.jr_addr = 32'hFFFF_FFFC;
    cyc("jr_top", 32'hFFFF_FFFC, 1, 0, 0);
    cyc("pc_wrap", 32'h0000_0000, 2, 0, 0);
    bus.br_taken = 1'b1; bus.br_imm = 16'hFFFF;
    cyc("br_minus1", 32'h0000_0000, 3, 0, 0);
    bus.jr = 1'b1; bus.jr_addr = 32'h0000_0003;
    cyc("jr_misalign2", 32'h0000_0000, 3, 0, 1);
    reset_n = 1'b0;
    cyc("reset_fault", 32'h0040_0020, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
